// File: rtl/seq_alu_flags.sv
// Multi-cycle ALU feeding the SAYEH status register: single-cycle logic/arith ops,
// iterative shift-add multiply, and C/Z flags with a one-cycle SR load strobe.
module seq_alu_flags #(
  parameter int WIDTH = 16,
  parameter int MUL_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_out,
  output logic             sr_load,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             legal_q, legal_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [MUL_W-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_z;

  assign sum_w    = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(Cin);
  // Borrow out of A-B-Cin shows up as the extra MSB of the widened difference.
  assign diff_w   = {1'b0, A} - {1'b0, B} - (WIDTH+1)'(Cin);
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    alu_res = result_q;
    alu_c   = carry_q;
    alu_z   = zero_q;
    case (opcode)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = ~A;
      4'b0011: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c   = A[WIDTH-1];
      end
      4'b0100: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      4'b0101: {alu_c, alu_res} = sum_w;
      4'b0110: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
      end
      4'b0111: begin
        alu_c = (A < B);
        alu_z = (A == B);
      end
      default: ;
    endcase
    if (opcode < 4'b0111) alu_z = ~|alu_res;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    legal_d  = legal_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mcand_d  = WIDTH'(A[MUL_W-1:0]);
            mplier_d = B[MUL_W-1:0];
            acc_d    = '0;
            cnt_d    = '0;
            legal_d  = 1'b1;
            state_d  = S_MUL;
          end else begin
            legal_d  = ~opcode[3];
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = alu_z;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[MUL_W-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step;
          carry_d  = 1'b0;
          zero_d   = ~|acc_step;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      legal_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      legal_q  <= legal_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sr_load   = (state_q == S_DONE) && legal_q;

endmodule
